tmds_timing: RTL and testbench
==============================

Name: tmds_timing

Overview:
- Recovers pixel/line position and active-video qualifier from the HDMI/TMDS receiver's decoded hsync/vsync.
- Sits directly after the TMDS decoder (rx0 channel) in the pixel-clock domain.
- Feeds downstream video-capture/packetizing logic with hcnt/vcnt coordinates and a data-enable.

Parameters:
- H_START, 260, hcnt value of the first active pixel, counted from the hsync leading edge (720p: 40 sync + 220 back porch).
- H_ACTIVE, 1280, active pixels per line.
- V_START, 25, vcnt value of the first active line, counted from the vsync leading edge (5 sync + 20 back porch).
- V_ACTIVE, 720, active lines per frame.
- SYNC_POL, 1, asserted level of hsync/vsync (1 = active-high, 0 = active-low).

Ports:
- rx0_pclk  in  1  pixel clock; all logic rises on it.
- rstbtn_n  in  1  reset, asynchronous, active-high despite the name; 1 = reset.
- rx0_hsync  in  1  decoded horizontal sync.
- rx0_vsync  in  1  decoded vertical sync.
- video_en  out  1  high while (video_hcnt, video_vcnt) lies in the active window.
- video_hcnt  out  11  pixel count since the last hsync leading edge.
- video_vcnt  out  11  line count since the last vsync leading edge.

Behaviour:
- Reset (rstbtn_n=1, asynchronous):
  - all registers 0; video_en=0, video_hcnt=0, video_vcnt=0.
  - Release is synchronised to rx0_pclk.
- Input stage:
  - hsync/vsync are XORed with ~SYNC_POL, then registered (stage s).
  - A second register holds the previous value (stage p).
  - Leading edge = s asserted and p deasserted.
  - A sync held asserted continuously produces exactly one edge.
- Horizontal counter:
  - On an hsync leading-edge cycle, video_hcnt <= 0.
  - Otherwise video_hcnt increments by 1 per clock and saturates at 2047; no wrap.
  - Latency: input hsync first sampled high at edge N gives video_hcnt=0 after edge N+2.
- Vertical counter:
  - On a vsync leading-edge cycle, video_vcnt <= 0.
  - Otherwise, on an hsync leading edge, video_vcnt increments by 1, saturating at 2047.
  - Simultaneous vsync and hsync edges: vsync wins, vcnt=0 and hcnt=0.
- video_en:
  - Registered and computed from the next-state counters, so it is always cycle-aligned with the counters on the outputs.
  - High iff H_START <= hcnt < H_START+H_ACTIVE and V_START <= vcnt < V_START+V_ACTIVE.
  - Window comparisons are done with 12-bit arithmetic so the end limits cannot overflow.
- Sync behaviour:
  - No sync-width checking; short or glitchy pulses still reset the counters.
  - Missing hsync: hcnt saturates at 2047 and video_en falls once hcnt reaches H_START+H_ACTIVE.
- Reset mid-operation: all outputs return to 0 immediately; counting resumes only at the next leading edges.

Optional Feature:
- Macro TIMING_LOCK_EN.
- Defined:
  - A lock flag clears on reset and sets on the first vsync leading edge.
  - video_en is additionally ANDed with lock, so no output appears in the first (partial) frame after reset.
  - Counters are unaffected.
- Undefined: no lock flag; video_en depends only on the counters, so a partial first frame may assert video_en.

Decomposition:
- Shared package holds:
  - 720p timing constants (H_START/H_ACTIVE/V_START/V_ACTIVE defaults);
  - counter width constant CNT_W=11;
  - saturation value 2047.
- One natural sub-module: sync_edge_det (polarity normalise, two-stage register, leading-edge pulse), instantiated twice for hsync and vsync.

Test Plan:
- Reset asserted 2 clocks with syncs toggling -> video_en=0, hcnt=0, vcnt=0 throughout reset.
- Single hsync pulse rising at edge N -> hcnt=0 after edge N+2; hcnt=259 at N+261; hcnt=1539 then 1540 with video_en still 0 while vcnt<25.
- vsync then 25 hsync pulses, 1650 clocks/line -> on line vcnt=25, video_en rises with hcnt=260 and falls with hcnt=1540; 1280 en-cycles per line.
- Line 745 (vcnt=V_START+V_ACTIVE) -> video_en stays 0 for the whole line.
- hsync held high 40 clocks, then absent 3000 clocks -> one hcnt reset only; hcnt saturates at 2047 and holds.
- vsync and hsync rising on the same clock -> vcnt=0, hcnt=0. With TIMING_LOCK_EN defined, video_en stays 0 before the first vsync even when counters are in the window.

Source files
------------

// File: rtl/tmds_timing_pkg.sv
// rtl/tmds_timing_pkg.sv - shared 720p timing constants and counter helpers for tmds_timing
package tmds_timing_pkg;

  localparam int CNT_W = 11;
  localparam logic [CNT_W-1:0] CNT_MAX = 11'd2047;

  localparam int H_START_720P  = 260;
  localparam int H_ACTIVE_720P = 1280;
  localparam int V_START_720P  = 25;
  localparam int V_ACTIVE_720P = 720;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + 1'b1;
  endfunction

endpackage

// File: rtl/tmds_timing_sync_edge_det.sv
// rtl/tmds_timing_sync_edge_det.sv - sync polarity normalise, two-stage register, registered leading-edge pulse
module sync_edge_det #(
  parameter logic SYNC_POL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic sync,
  output logic lead
);

  logic s;
  logic p;

  // s is the normalised sync (1 = asserted); lead fires once per assertion
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s    <= 1'b0;
      p    <= 1'b0;
      lead <= 1'b0;
    end else begin
      s    <= sync ^ ~SYNC_POL;
      p    <= s;
      lead <= s & ~p;
    end
  end

endmodule

// File: rtl/tmds_timing.sv
// rtl/tmds_timing.sv - pixel/line position and data-enable recovery from decoded TMDS syncs
// Optional macro TIMING_LOCK_EN gates video_en until the first vsync leading edge after reset.
module tmds_timing
  import tmds_timing_pkg::*;
#(
  parameter int   H_START  = H_START_720P,
  parameter int   H_ACTIVE = H_ACTIVE_720P,
  parameter int   V_START  = V_START_720P,
  parameter int   V_ACTIVE = V_ACTIVE_720P,
  parameter logic SYNC_POL = 1'b1
) (
  input  logic              rx0_pclk,
  input  logic              rstbtn_n,
  input  logic              rx0_hsync,
  input  logic              rx0_vsync,
  output logic              video_en,
  output logic [CNT_W-1:0]  video_hcnt,
  output logic [CNT_W-1:0]  video_vcnt
);

  localparam logic [CNT_W:0] H_LO = (CNT_W+1)'(H_START);
  localparam logic [CNT_W:0] H_HI = (CNT_W+1)'(H_START + H_ACTIVE);
  localparam logic [CNT_W:0] V_LO = (CNT_W+1)'(V_START);
  localparam logic [CNT_W:0] V_HI = (CNT_W+1)'(V_START + V_ACTIVE);

  // Assert asynchronously, release on the second clock edge
  logic [1:0] rst_sync;
  logic       rst;

  always_ff @(posedge rx0_pclk or posedge rstbtn_n) begin
    if (rstbtn_n) rst_sync <= 2'b11;
    else          rst_sync <= {rst_sync[0], 1'b0};
  end

  assign rst = rst_sync[1];

  logic hs_lead;
  logic vs_lead;

  sync_edge_det #(.SYNC_POL(SYNC_POL)) u_hs_det (
    .clk  (rx0_pclk),
    .rst  (rst),
    .sync (rx0_hsync),
    .lead (hs_lead)
  );

  sync_edge_det #(.SYNC_POL(SYNC_POL)) u_vs_det (
    .clk  (rx0_pclk),
    .rst  (rst),
    .sync (rx0_vsync),
    .lead (vs_lead)
  );

  logic [CNT_W-1:0] hcnt_nxt;
  logic [CNT_W-1:0] vcnt_nxt;
  logic [CNT_W:0]   h_ext;
  logic [CNT_W:0]   v_ext;
  logic             win;
  logic             en_nxt;

  always_comb begin
    hcnt_nxt = hs_lead ? '0 : sat_inc(video_hcnt);
    vcnt_nxt = video_vcnt;
    if (vs_lead)      vcnt_nxt = '0;
    else if (hs_lead) vcnt_nxt = sat_inc(video_vcnt);
  end

  // One extra bit keeps START+ACTIVE from wrapping in the compare
  assign h_ext = {1'b0, hcnt_nxt};
  assign v_ext = {1'b0, vcnt_nxt};
  assign win   = (h_ext >= H_LO) && (h_ext < H_HI) && (v_ext >= V_LO) && (v_ext < V_HI);

`ifdef TIMING_LOCK_EN
  logic lock;

  always_ff @(posedge rx0_pclk or posedge rst) begin
    if (rst) lock <= 1'b0;
    else     lock <= lock | vs_lead;
  end

  assign en_nxt = win & (lock | vs_lead);
`else
  assign en_nxt = win;
`endif

  always_ff @(posedge rx0_pclk or posedge rst) begin
    if (rst) begin
      video_hcnt <= '0;
      video_vcnt <= '0;
      video_en   <= 1'b0;
    end else begin
      video_hcnt <= hcnt_nxt;
      video_vcnt <= vcnt_nxt;
      video_en   <= en_nxt;
    end
  end

endmodule

// File: tb/tb_tmds_timing.sv
// tb/tb_tmds_timing.sv - directed self-checking bench for tmds_timing
module tb_tmds_timing;

  logic        rx0_pclk = 1'b0;
  logic        rstbtn_n;
  logic        rx0_hsync;
  logic        rx0_vsync;
  logic        video_en;
  logic [10:0] video_hcnt;
  logic [10:0] video_vcnt;

  int checks = 0;
  int errors = 0;

  int l_h3, l_v3, l_en, l_first, l_fall, l_zero, l_last_h, l_last_en;

  tmds_timing dut (
    .rx0_pclk   (rx0_pclk),
    .rstbtn_n   (rstbtn_n),
    .rx0_hsync  (rx0_hsync),
    .rx0_vsync  (rx0_vsync),
    .video_en   (video_en),
    .video_hcnt (video_hcnt),
    .video_vcnt (video_vcnt)
  );

  always #5 rx0_pclk = ~rx0_pclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge rx0_pclk);
      #1;
    end
  endtask

  // One line: hsync high for hi clocks from the start, len clocks total
  task automatic run_line(input logic vs, input int hi, input int len);
    l_h3 = -1; l_v3 = -1; l_en = 0; l_first = -1; l_fall = -1; l_zero = 0;
    rx0_hsync = 1'b1;
    rx0_vsync = vs;
    for (int i = 0; i < len; i++) begin
      if (i == hi) rx0_hsync = 1'b0;
      step(1);
      if (i == 2) begin
        l_h3 = int'(video_hcnt);
        l_v3 = int'(video_vcnt);
      end
      if (video_hcnt == 11'd0) l_zero++;
      if (video_en) begin
        l_en++;
        if (l_first < 0) l_first = int'(video_hcnt);
      end else if (l_first >= 0 && l_fall < 0) begin
        l_fall = int'(video_hcnt);
      end
    end
    l_last_h  = int'(video_hcnt);
    l_last_en = int'(video_en);
  endtask

  initial begin
    rstbtn_n  = 1'b1;
    rx0_hsync = 1'b0;
    rx0_vsync = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      rx0_hsync = ~rx0_hsync;
      rx0_vsync = ~rx0_vsync;
      step(1);
      chk("rst_en",   video_en,   0);
      chk("rst_hcnt", video_hcnt, 0);
      chk("rst_vcnt", video_vcnt, 0);
    end
    rx0_hsync = 1'b0;
    rx0_vsync = 1'b0;
    rstbtn_n  = 1'b0;
    step(6);

    // single hsync pulse: 0 after N+2, then free count
    rx0_hsync = 1'b1;
    step(1);
    rx0_hsync = 1'b0;
    step(2);
    chk("p1_hcnt0", video_hcnt, 0);
    chk("p1_vcnt1", video_vcnt, 1);
    step(259);
    chk("p1_hcnt259", video_hcnt, 259);
    step(1280);
    chk("p1_hcnt1539", video_hcnt, 1539);
    chk("p1_en1539", video_en, 0);
    step(1);
    chk("p1_hcnt1540", video_hcnt, 1540);
    chk("p1_en1540", video_en, 0);

    // counters in the window before any vsync
    for (int i = 0; i < 23; i++) run_line(1'b0, 5, 50);
    chk("pre_v24", l_v3, 24);
    run_line(1'b0, 40, 1650);
    chk("pre_v25", l_v3, 25);
`ifdef TIMING_LOCK_EN
    chk("pre_lock_en", l_en, 0);
`else
    chk("pre_nolock_en", l_en, 1280);
`endif

    // frame A: vsync and hsync together, vsync held 5 lines
    run_line(1'b1, 5, 50);
    chk("fa_sim_hcnt", l_h3, 0);
    chk("fa_sim_vcnt", l_v3, 0);
    for (int i = 0; i < 4; i++) run_line(1'b1, 5, 50);
    chk("fa_vs_held_v4", l_v3, 4);
    for (int i = 0; i < 20; i++) run_line(1'b0, 5, 50);
    chk("fa_v24", l_v3, 24);
    chk("fa_v24_en", l_en, 0);
    run_line(1'b0, 40, 1650);
    chk("fa_v25", l_v3, 25);
    chk("fa_v25_en", l_en, 1280);
    chk("fa_v25_rise_h", l_first, 260);
    chk("fa_v25_fall_h", l_fall, 1540);
    for (int i = 0; i < 718; i++) run_line(1'b0, 5, 50);
    chk("fa_v743", l_v3, 743);
    run_line(1'b0, 40, 1650);
    chk("fa_v744", l_v3, 744);
    chk("fa_v744_en", l_en, 1280);
    run_line(1'b0, 40, 1650);
    chk("fa_v745", l_v3, 745);
    chk("fa_v745_en", l_en, 0);

    // frame B: hsync held 40 then absent, hcnt saturates
    run_line(1'b1, 5, 50);
    chk("fb_v0", l_v3, 0);
    for (int i = 0; i < 24; i++) run_line(1'b0, 5, 50);
    run_line(1'b0, 40, 3040);
    chk("miss_v25", l_v3, 25);
    chk("miss_zero_once", l_zero, 1);
    chk("miss_en", l_en, 1280);
    chk("miss_fall_h", l_fall, 1540);
    chk("miss_sat", l_last_h, 2047);
    chk("miss_en_end", l_last_en, 0);
    step(5);
    chk("miss_sat_hold", video_hcnt, 2047);

    // reset mid-operation clears outputs without waiting for a clock
    rstbtn_n = 1'b1;
    #1;
    chk("mid_rst_hcnt", video_hcnt, 0);
    chk("mid_rst_vcnt", video_vcnt, 0);
    chk("mid_rst_en",   video_en,   0);
    step(2);
    chk("mid_rst_hold", video_hcnt, 0);
    rstbtn_n = 1'b0;
    step(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
